dds_param_ctrl: RTL and testbench
=================================

DDS_PARAM_CTRL -- requirements
Module: dds_param_ctrl

Interface
REQ-001 Parameter CH_NUM, default 5: number of DDS channels; channel 0 is the amplitude reference channel.
REQ-002 Parameter DEB_CYC, default 1_000_000: debounce stability time in clocks (20 ms).
REQ-003 Parameter HOLD_CYC, default 25_000_000: hold time before auto-repeat starts (0.5 s).
REQ-004 Parameter REP_CYC, default 5_000_000: auto-repeat period (100 ms).
REQ-005 Parameters FREQ_STEP 131072, PHASE_STEP 11_930_464, FREQ_MAX 100, PHASE_MAX 359, AMP_MAX 100: step words and count limits.
REQ-006 clk_50m  in  1  system clock; reset rst_n, asynchronous, active-low; clock clk_50m.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 key  in  4  raw active-low buttons: [0] field select, [1] channel select, [2] increment, [3] decrement.
REQ-009 wave_freq  out  32  common frequency tuning word, freq_cnt*FREQ_STEP.
REQ-010 phase_bus  out  32*CH_NUM  per-channel phase word, slice c = phase_cnt[c]*PHASE_STEP.
REQ-011 amp_bus  out  8*CH_NUM  per-channel amplitude percent, unsigned.
REQ-012 sel_field  out  3  one-hot field: 001 freq, 010 phase, 100 amp.
REQ-013 sel_ch  out  $clog2(CH_NUM)  selected channel index.
REQ-014 disp_val  out  9  count of the selected field/channel, for seg_led.
REQ-015 param_upd  out  1  one-cycle pulse when any count changes.

Function
REQ-016 Each key passes a 2-FF synchroniser, then is accepted as changed only after DEB_CYC consecutive equal samples.
REQ-017 A press event occurs on the debounced 1->0 transition; releases produce no event.
REQ-018 For key[2]/key[3], a key held HOLD_CYC cycles after its press event produces a repeat event, then one every REP_CYC cycles while held; release stops repeats immediately.
REQ-019 key[0] event rotates sel_field 001->010->100->001.
REQ-020 key[1] event increments sel_ch, wrapping CH_NUM-1 -> 0.
REQ-021 An inc event adds 1 to the selected count; at max it wraps to min.
REQ-022 A dec event subtracts 1 from the selected count; at min it wraps to max.
REQ-023 Ranges: freq_cnt 1..FREQ_MAX, phase_cnt 0..PHASE_MAX, amp_cnt 0..AMP_MAX.
REQ-024 In the freq field, inc/dec act on freq_cnt regardless of sel_ch.
REQ-025 Amplitude of channel 0 is fixed at AMP_MAX; inc/dec on it are ignored with no param_upd.
REQ-026 Inc and dec events in the same cycle are both ignored.
REQ-027 A select event (key[0]/key[1]) in the same cycle as inc/dec takes priority; the adjust is dropped.
REQ-028 Counts update on the clock after the event; wave_freq, phase_bus, amp_bus, disp_val and param_upd are registered and valid one further clock later (2-cycle latency from event).
REQ-029 Step multiplications are truncated to 32 bits.

Reset
REQ-030 Reset values: sel_field 001, sel_ch 0, freq_cnt 1, all phase_cnt 0, amp_cnt[0] AMP_MAX, others 0, param_upd 0.
REQ-031 Debounce state resets to "released"; a key held low through reset release yields one press event after DEB_CYC.
REQ-032 Reset asserted mid-hold or mid-repeat clears all repeat and debounce counters; no event is emitted.

Structure
REQ-033 Step words, limits and field encodings live in shared package dds_pkg.
REQ-034 Debounce plus press/repeat generation is sub-module key_debounce, instantiated once per key; repeat is enabled by parameter only for key[2]/key[3].
REQ-035 Counts are held in per-channel register arrays generated over CH_NUM.

Verification (bench uses DEB_CYC 4, HOLD_CYC 20, REP_CYC 5)
REQ-036 Reset, no keys -> wave_freq 131072, phase_bus 0, amp_bus slice0 100, others 0, sel_field 001.
REQ-037 key[2] bounce 1-0-1-0, then held low 10 cycles and released -> exactly one increment, freq_cnt 2, one param_upd pulse.
REQ-038 freq field, key[3] press at freq_cnt 1 -> freq_cnt 100, wave_freq 13_107_200.
REQ-039 Phase field, ch 2, key[2] held 40 cycles -> 1 press plus repeats at 20, 25, 30, 35 cycles after the press: phase_cnt[2] 5, phase_bus slice2 59_652_320.
REQ-040 Amp field, ch 0, key[2] press -> amp_bus unchanged, no param_upd; ch 4 at 100, inc -> 0.
REQ-041 key[2] and key[3] debounced in the same cycle -> no change; key[1] with key[2] simultaneously -> sel_ch+1, count unchanged.

Source files
------------

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared step words, count limits, field encodings and wrap helper
package dds_pkg;

    // Width of every adjustable count (phase reaches 359).
    localparam int CNT_W = 9;

    localparam int unsigned FREQ_STEP_DEF  = 131072;
    localparam int unsigned PHASE_STEP_DEF = 11_930_464;
    localparam int unsigned FREQ_MIN       = 1;
    localparam int unsigned FREQ_MAX_DEF   = 100;
    localparam int unsigned PHASE_MAX_DEF  = 359;
    localparam int unsigned AMP_MAX_DEF    = 100;

    typedef enum logic [2:0] {
        FLD_FREQ  = 3'b001,
        FLD_PHASE = 3'b010,
        FLD_AMP   = 3'b100
    } field_t;

    // One step up or down inside [lo, hi], wrapping at either end.
    function automatic logic [CNT_W-1:0] step_wrap(
        input logic [CNT_W-1:0] val,
        input logic             up,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        if (up) begin
            return (val >= hi) ? lo : val + 1'b1;
        end
        return (val <= lo) ? hi : val - 1'b1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - key synchroniser, debouncer, press and auto-repeat event generator
//
// Ports:
//   clk_50m      system clock
//   rst_n        asynchronous active-low reset
//   key_in       raw active-low key
//   event_pulse  one-cycle pulse per press event and per auto-repeat event
module key_debounce #(
    parameter int unsigned DEB_CYC  = 1_000_000,
    parameter int unsigned HOLD_CYC = 25_000_000,
    parameter int unsigned REP_CYC  = 5_000_000,
    parameter bit          REP_EN   = 1'b0
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic key_in,
    output logic event_pulse
);

    localparam int DEB_W = $clog2(DEB_CYC + 1);
    localparam int REP_W = $clog2(HOLD_CYC + 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [DEB_W-1:0] deb_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic             accept;

    // The synchronised level has differed from the debounced level long enough.
    assign accept = (sync2 != stable) && (deb_cnt == DEB_W'(DEB_CYC - 1));

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            stable      <= 1'b1;
            deb_cnt     <= '0;
            rep_cnt     <= '0;
            event_pulse <= 1'b0;
        end else begin
            sync1       <= key_in;
            sync2       <= sync1;
            event_pulse <= 1'b0;

            if (sync2 != stable) begin
                deb_cnt <= accept ? '0 : deb_cnt + 1'b1;
            end else begin
                deb_cnt <= '0;
            end

            if (accept) begin
                // A debounced release also lands here, so repeats stop on it.
                stable      <= sync2;
                rep_cnt     <= '0;
                event_pulse <= !sync2;
            end else if (REP_EN && !stable) begin
                // rep_cnt counts cycles since the press; after each repeat it is
                // rewound so the next one falls REP_CYC cycles later.
                if (rep_cnt == REP_W'(HOLD_CYC - 1)) begin
                    event_pulse <= 1'b1;
                    rep_cnt     <= REP_W'(HOLD_CYC - REP_CYC);
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dds_param_ctrl.sv
// rtl/dds_param_ctrl.sv - button driven DDS frequency/phase/amplitude parameter controller
//
// Ports:
//   clk_50m    system clock
//   rst_n      asynchronous active-low reset
//   key        raw active-low keys: [0] field, [1] channel, [2] inc, [3] dec
//   wave_freq  common frequency tuning word
//   phase_bus  per-channel phase words, 32 bits per channel
//   amp_bus    per-channel amplitude percent, 8 bits per channel
//   sel_field  one-hot selected field (freq/phase/amp)
//   sel_ch     selected channel
//   disp_val   count of the selected field/channel
//   param_upd  one-cycle pulse when a count changes
module dds_param_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned CH_NUM     = 5,
    parameter int unsigned DEB_CYC    = 1_000_000,
    parameter int unsigned HOLD_CYC   = 25_000_000,
    parameter int unsigned REP_CYC    = 5_000_000,
    parameter int unsigned FREQ_STEP  = FREQ_STEP_DEF,
    parameter int unsigned PHASE_STEP = PHASE_STEP_DEF,
    parameter int unsigned FREQ_MAX   = FREQ_MAX_DEF,
    parameter int unsigned PHASE_MAX  = PHASE_MAX_DEF,
    parameter int unsigned AMP_MAX    = AMP_MAX_DEF
) (
    input  logic                       clk_50m,
    input  logic                       rst_n,
    input  logic [3:0]                 key,
    output logic [31:0]                wave_freq,
    output logic [32*CH_NUM-1:0]       phase_bus,
    output logic [8*CH_NUM-1:0]        amp_bus,
    output logic [2:0]                 sel_field,
    output logic [$clog2(CH_NUM)-1:0]  sel_ch,
    output logic [8:0]                 disp_val,
    output logic                       param_upd
);

    localparam int CH_W = $clog2(CH_NUM);

    logic [3:0]       evt;
    field_t           field_q;
    field_t           field_d;
    logic             adj_valid;
    logic             adj_up;
    logic             changed;
    logic             upd_pend;
    logic [CNT_W-1:0] freq_cnt;
    logic [CNT_W-1:0] phase_cnt [CH_NUM];
    logic [CNT_W-1:0] amp_cnt   [CH_NUM];

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEB_CYC  (DEB_CYC),
            .HOLD_CYC (HOLD_CYC),
            .REP_CYC  (REP_CYC),
            .REP_EN   ((k >= 2) ? 1'b1 : 1'b0)
        ) u_key (
            .clk_50m     (clk_50m),
            .rst_n       (rst_n),
            .key_in      (key[k]),
            .event_pulse (evt[k])
        );
    end

    // Select keys win over adjust keys; inc together with dec cancels.
    assign adj_valid = !(evt[0] || evt[1]) && (evt[2] ^ evt[3]);
    assign adj_up    = evt[2];
    // Channel 0 amplitude is the fixed reference, so adjusting it changes nothing.
    assign changed   = adj_valid && !(field_q == FLD_AMP && sel_ch == '0);

    // Field select state machine
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            field_q <= FLD_FREQ;
        end else begin
            field_q <= field_d;
        end
    end

    always_comb begin
        field_d = field_q;
        if (evt[0]) begin
            unique case (field_q)
                FLD_FREQ:  field_d = FLD_PHASE;
                FLD_PHASE: field_d = FLD_AMP;
                default:   field_d = FLD_FREQ;
            endcase
        end
    end

    always_comb begin
        sel_field = field_q;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sel_ch <= '0;
        end else if (evt[1]) begin
            sel_ch <= (sel_ch == CH_W'(CH_NUM - 1)) ? '0 : sel_ch + 1'b1;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            freq_cnt <= CNT_W'(FREQ_MIN);
        end else if (adj_valid && field_q == FLD_FREQ) begin
            freq_cnt <= step_wrap(freq_cnt, adj_up, CNT_W'(FREQ_MIN), CNT_W'(FREQ_MAX));
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [CNT_W-1:0] phase_q;
        logic [CNT_W-1:0] amp_q;
        logic [31:0]      phase_word;
        logic [7:0]       amp_word;
        logic             ch_hit;

        assign ch_hit = (sel_ch == CH_W'(c));

        always_ff @(posedge clk_50m or negedge rst_n) begin
            if (!rst_n) begin
                phase_q <= '0;
            end else if (adj_valid && field_q == FLD_PHASE && ch_hit) begin
                phase_q <= step_wrap(phase_q, adj_up, '0, CNT_W'(PHASE_MAX));
            end
        end

        if (c == 0) begin : g_ref
            assign amp_q = CNT_W'(AMP_MAX);
        end else begin : g_adj
            always_ff @(posedge clk_50m or negedge rst_n) begin
                if (!rst_n) begin
                    amp_q <= '0;
                end else if (adj_valid && field_q == FLD_AMP && ch_hit) begin
                    amp_q <= step_wrap(amp_q, adj_up, '0, CNT_W'(AMP_MAX));
                end
            end
        end

        always_ff @(posedge clk_50m or negedge rst_n) begin
            if (!rst_n) begin
                phase_word <= '0;
                amp_word   <= (c == 0) ? 8'(AMP_MAX) : 8'd0;
            end else begin
                phase_word <= 32'(phase_q) * PHASE_STEP;
                amp_word   <= amp_q[7:0];
            end
        end

        assign phase_cnt[c]          = phase_q;
        assign amp_cnt[c]            = amp_q;
        assign phase_bus[c*32 +: 32] = phase_word;
        assign amp_bus[c*8 +: 8]     = amp_word;
    end

    // Output stage: one register after the counts, so everything the display
    // and the DDS core see moves together two clocks after the key event.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wave_freq <= FREQ_STEP;
            disp_val  <= 9'(FREQ_MIN);
            upd_pend  <= 1'b0;
            param_upd <= 1'b0;
        end else begin
            wave_freq <= 32'(freq_cnt) * FREQ_STEP;
            upd_pend  <= changed;
            param_upd <= upd_pend;
            case (field_q)
                FLD_PHASE: disp_val <= phase_cnt[sel_ch];
                FLD_AMP:   disp_val <= amp_cnt[sel_ch];
                default:   disp_val <= freq_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_param_ctrl.sv
// tb/tb_dds_param_ctrl.sv - scoreboard bench for dds_param_ctrl against a behavioural model
module tb_dds_param_ctrl;

    localparam int CH   = 5;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;
    localparam longint PSTEP = 11930464;
    localparam longint FSTEP = 131072;

    logic           clk_50m = 1'b0;
    logic           rst_n   = 1'b0;
    logic [3:0]     key     = 4'hF;
    logic [31:0]    wave_freq;
    logic [159:0]   phase_bus;
    logic [39:0]    amp_bus;
    logic [2:0]     sel_field;
    logic [2:0]     sel_ch;
    logic [8:0]     disp_val;
    logic           param_upd;

    dds_param_ctrl #(
        .CH_NUM   (CH),
        .DEB_CYC  (DEB),
        .HOLD_CYC (HOLD),
        .REP_CYC  (REP)
    ) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .key       (key),
        .wave_freq (wave_freq),
        .phase_bus (phase_bus),
        .amp_bus   (amp_bus),
        .sel_field (sel_field),
        .sel_ch    (sel_ch),
        .disp_val  (disp_val),
        .param_upd (param_upd)
    );

    always #10 clk_50m = ~clk_50m;

    int cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]  wf;
        logic [159:0] pb;
        logic [39:0]  ab;
        logic [8:0]   dv;
    } snap_t;

    snap_t exp_q[$];
    int    upd_cyc[$];
    snap_t mon_s;
    int    n_chk  = 0;
    int    n_fail = 0;

    // Behavioural model state: field 0/1/2 = freq/phase/amp
    int m_fld, m_ch, m_freq;
    int m_ph  [CH];
    int m_amp [CH];

    function automatic void check(string name, logic [159:0] act, logic [159:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endfunction

    function automatic void model_reset();
        m_fld = 0; m_ch = 0; m_freq = 1;
        for (int c = 0; c < CH; c++) begin
            m_ph[c]  = 0;
            m_amp[c] = (c == 0) ? 100 : 0;
        end
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        longint w;
        s.wf = 32'(longint'(m_freq) * FSTEP);
        s.pb = '0;
        s.ab = '0;
        for (int c = 0; c < CH; c++) begin
            w = longint'(m_ph[c]) * PSTEP;
            s.pb[c*32 +: 32] = w[31:0];
            s.ab[c*8 +: 8]   = 8'(m_amp[c]);
        end
        case (m_fld)
            0:       s.dv = 9'(m_freq);
            1:       s.dv = 9'(m_ph[m_ch]);
            default: s.dv = 9'(m_amp[m_ch]);
        endcase
        return s;
    endfunction

    function automatic void model_adjust(bit up, bit dn);
        if (up == dn) return;
        case (m_fld)
            0: m_freq = up ? ((m_freq == 100) ? 1 : m_freq + 1) : ((m_freq == 1) ? 100 : m_freq - 1);
            1: m_ph[m_ch] = up ? ((m_ph[m_ch] == 359) ? 0 : m_ph[m_ch] + 1)
                               : ((m_ph[m_ch] == 0) ? 359 : m_ph[m_ch] - 1);
            default: begin
                if (m_ch == 0) return;
                m_amp[m_ch] = up ? ((m_amp[m_ch] == 100) ? 0 : m_amp[m_ch] + 1)
                                 : ((m_amp[m_ch] == 0) ? 100 : m_amp[m_ch] - 1);
            end
        endcase
        exp_q.push_back(model_snap());
    endfunction

    // A key held low for `hold` cycles: one press, then repeats (inc/dec only)
    // at HOLD, HOLD+REP, ... cycles after the press while still held.
    function automatic void model_press(bit [3:0] m, int hold);
        int nrep;
        if (m[0]) m_fld = (m_fld + 1) % 3;
        if (m[1]) m_ch = (m_ch + 1) % CH;
        if (!(m[0] || m[1])) model_adjust(m[2], m[3]);
        nrep = (hold > HOLD) ? (hold - HOLD - 1) / REP + 1 : 0;
        for (int i = 0; i < nrep; i++) model_adjust(m[2], m[3]);
    endfunction

    task automatic check_idle();
        snap_t s;
        @(negedge clk_50m);
        s = model_snap();
        check("sel_field", sel_field, 160'(3'b001 << m_fld));
        check("sel_ch", sel_ch, 160'(m_ch));
        check("wave_freq", wave_freq, s.wf);
        check("phase_bus", phase_bus, s.pb);
        check("amp_bus", amp_bus, s.ab);
        check("disp_val", disp_val, s.dv);
        check("pending_upd", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic press_key(bit [3:0] m, int hold);
        model_press(m, hold);
        @(posedge clk_50m); #1 key = ~m;
        repeat (hold) @(posedge clk_50m);
        #1 key = 4'hF;
        repeat (14) @(posedge clk_50m);
        check_idle();
    endtask

    // Monitor: every param_upd pulse consumes one expected snapshot.
    always @(negedge clk_50m) begin
        if (rst_n && param_upd) begin
            upd_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL upd_unexpected: actual pulse at cycle %0d required none", cyc);
            end else begin
                mon_s = exp_q.pop_front();
                check("upd_wave_freq", wave_freq, mon_s.wf);
                check("upd_phase_bus", phase_bus, mon_s.pb);
                check("upd_amp_bus", amp_bus, mon_s.ab);
                check("upd_disp_val", disp_val, mon_s.dv);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, h;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk_50m);

        // Reset state
        check_idle();
        check("reset_wave_freq", wave_freq, 160'(131072));
        check("reset_amp0", amp_bus[7:0], 160'(100));
        check("reset_param_upd", param_upd, 0);

        // Bouncy increment press: exactly one update
        upd_cyc.delete();
        model_press(4'b0100, 10);
        @(posedge clk_50m); #1 key = 4'b1011;
        @(posedge clk_50m); #1 key = 4'hF;
        @(posedge clk_50m); #1 key = 4'b1011;
        @(posedge clk_50m); #1 key = 4'hF;
        @(posedge clk_50m); #1 key = 4'b1011;
        repeat (10) @(posedge clk_50m);
        #1 key = 4'hF;
        repeat (14) @(posedge clk_50m);
        check_idle();
        check("bounce_pulses", upd_cyc.size(), 1);

        // Decrement wrap 1 -> 100
        press_key(4'b1000, 10);
        press_key(4'b1000, 10);
        check("freq_wrap_word", wave_freq, 160'(13_107_200));

        // Phase field, channel 2, held 40 cycles: press plus four repeats
        press_key(4'b0001, 10);
        press_key(4'b0010, 10);
        press_key(4'b0010, 10);
        upd_cyc.delete();
        press_key(4'b0100, 40);
        check("repeat_pulses", upd_cyc.size(), 5);
        if (upd_cyc.size() == 5) begin
            check("repeat_gap1", upd_cyc[1] - upd_cyc[0], 20);
            check("repeat_gap2", upd_cyc[2] - upd_cyc[1], 5);
            check("repeat_gap3", upd_cyc[3] - upd_cyc[2], 5);
            check("repeat_gap4", upd_cyc[4] - upd_cyc[3], 5);
        end
        check("phase2_word", phase_bus[95:64], 160'(59_652_320));

        // Amp field: channel 0 locked, channel 4 wraps
        press_key(4'b0001, 10);
        for (int i = 0; i < 3; i++) press_key(4'b0010, 10);
        upd_cyc.delete();
        press_key(4'b0100, 10);
        check("amp0_locked", amp_bus[7:0], 160'(100));
        check("amp0_no_upd", upd_cyc.size(), 0);
        for (int i = 0; i < 4; i++) press_key(4'b0010, 10);
        press_key(4'b1000, 10);
        press_key(4'b0100, 10);
        check("amp4_wrap", amp_bus[39:32], 0);

        // Simultaneous keys
        press_key(4'b1100, 10);
        press_key(4'b0110, 10);

        // Randomised key sequences
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            h = ($urandom_range(0, 1) != 0) ? 10 : $urandom_range(21, 34);
            case (r)
                0:       press_key(4'b0001, 10);
                1:       press_key(4'b0010, 10);
                2, 3:    press_key(4'b0100, h);
                4, 5:    press_key(4'b1000, h);
                6:       press_key(4'b1100, 10);
                7:       press_key(4'b0110, 10);
                8:       press_key(4'b0101, 10);
                default: press_key(4'b1010, 10);
            endcase
        end

        // Reset mid-repeat with the key still held through reset release
        model_adjust(1'b1, 1'b0);
        model_adjust(1'b1, 1'b0);
        @(posedge clk_50m); #1 key = 4'b1011;
        repeat (30) @(posedge clk_50m);
        #1 rst_n = 1'b0;
        check("reset_drained", exp_q.size(), 0);
        model_reset();
        repeat (3) @(posedge clk_50m);
        check_idle();
        @(posedge clk_50m); #1 rst_n = 1'b1;
        model_adjust(1'b1, 1'b0);
        repeat (10) @(posedge clk_50m);
        #1 key = 4'hF;
        repeat (14) @(posedge clk_50m);
        check_idle();

        repeat (5) @(posedge clk_50m);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
